// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_gen
// Description : VGA test-pattern generator with built-in H/V timing.
//               Patterns: solid, scrolling checkerboard, 8-colour bars and
//               border. The configuration is captured once per frame. RGB,
//               sync, data-enable and frame_start are registered together.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int TILE_LOG2  = 5,
    parameter int COLOR_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic [2:0]            fg_index,
    input  logic                  scroll_en,
    output logic                  hsync,
    output logic                  vsync,
    output logic [COLOR_BITS-1:0] r,
    output logic [COLOR_BITS-1:0] g,
    output logic [COLOR_BITS-1:0] b,
    output logic                  de,
    output logic                  frame_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = $clog2(c_H_TOTAL);
    localparam int c_VW      = $clog2(c_V_TOTAL);
    localparam int c_SW      = TILE_LOG2 + 1;
    localparam int c_XW      = ((c_HW > c_SW) ? c_HW : c_SW) + 1;
    localparam int c_BAR_PX  = H_ACTIVE / 8;
    localparam int c_BW      = (c_BAR_PX > 1) ? $clog2(c_BAR_PX) : 1;

    localparam logic [c_HW-1:0] c_H_LAST     = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_ACT      = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_H_ACT_LAST = c_HW'(H_ACTIVE - 1);
    localparam logic [c_HW-1:0] c_HS_BEG     = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_HS_END     = c_HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [c_VW-1:0] c_V_LAST     = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_ACT      = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_V_ACT_LAST = c_VW'(V_ACTIVE - 1);
    localparam logic [c_VW-1:0] c_VS_BEG     = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_VS_END     = c_VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [c_BW-1:0] c_BAR_LAST   = c_BW'(c_BAR_PX - 1);

    logic [c_HW-1:0] r_hcnt;
    logic [c_VW-1:0] r_vcnt;
    logic [1:0]      r_cfg_mode;
    logic [2:0]      r_cfg_fg;
    logic [c_SW-1:0] r_scroll;
    logic [c_BW-1:0] r_bar_cnt;
    logic [2:0]      r_bar_idx;

    logic            w_frame_end;
    logic            w_active;
    logic            w_hsync_n;
    logic            w_vsync_n;
    logic [c_XW-1:0] w_hsum;
    logic            w_checker;
    logic            w_border;
    logic            w_on;
    logic [2:0]      w_idx;

    assign w_frame_end = (r_hcnt == c_H_LAST) && (r_vcnt == c_V_LAST);
    assign w_active    = (r_hcnt < c_H_ACT) && (r_vcnt < c_V_ACT);
    assign w_hsync_n   = !((r_hcnt >= c_HS_BEG) && (r_hcnt <= c_HS_END));
    assign w_vsync_n   = !((r_vcnt >= c_VS_BEG) && (r_vcnt <= c_VS_END));
    // Horizontal scroll shifts the tile phase; only the tile-select bit matters.
    assign w_hsum      = c_XW'(r_hcnt) + c_XW'(r_scroll);
    assign w_checker   = w_hsum[TILE_LOG2] ^ r_vcnt[TILE_LOG2];
    assign w_border    = (r_hcnt == '0) || (r_hcnt == c_H_ACT_LAST) ||
                         (r_vcnt == '0) || (r_vcnt == c_V_ACT_LAST);

    // Horizontal and vertical raster counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_hcnt == c_H_LAST) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == c_V_LAST) ? '0 : r_vcnt + 1'b1;
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    // Frame-boundary capture of configuration and scroll advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_mode <= 2'd0;
            r_cfg_fg   <= 3'b111;
            r_scroll   <= '0;
        end else if (w_frame_end) begin
            r_cfg_mode <= mode;
            r_cfg_fg   <= fg_index;
            if (scroll_en) begin
                r_scroll <= r_scroll + 1'b1;
            end
        end
    end

    // Bar-width counter and bar index; both hold zero at the start of each line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bar_cnt <= '0;
            r_bar_idx <= 3'd0;
        end else if (r_hcnt == c_H_LAST) begin
            r_bar_cnt <= '0;
            r_bar_idx <= 3'd0;
        end else if (r_bar_cnt == c_BAR_LAST) begin
            r_bar_cnt <= '0;
            r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
            r_bar_cnt <= r_bar_cnt + 1'b1;
        end
    end

    // Pattern decode: pick palette index and whether the pixel is lit.
    always_comb begin
        w_idx = r_cfg_fg;
        w_on  = 1'b0;
        case (r_cfg_mode)
            2'd0: w_on = 1'b1;
            2'd1: w_on = w_checker;
            2'd2: begin
                w_on  = 1'b1;
                w_idx = ~r_bar_idx;     // 7 - index: white on the left
            end
            default: w_on = w_border;
        endcase
    end

    // Output register stage keeps sync, de, colour and frame_start aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            frame_start <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
        end else begin
            hsync       <= w_hsync_n;
            vsync       <= w_vsync_n;
            de          <= w_active;
            frame_start <= (r_hcnt == '0) && (r_vcnt == '0);
            r           <= {COLOR_BITS{w_active & w_on & w_idx[2]}};
            g           <= {COLOR_BITS{w_active & w_on & w_idx[1]}};
            b           <= {COLOR_BITS{w_active & w_on & w_idx[0]}};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vga_pattern_gen
// Description : Self-checking bench for vga_pattern_gen using a reduced
//               raster and a position-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pattern_gen;

    localparam int HA = 32, HFP = 4, HS = 8, HB = 4;
    localparam int VA = 24, VFP = 2, VS = 2, VB = 4;
    localparam int T  = 2;
    localparam int CB = 2;
    localparam int HT = HA + HFP + HS + HB;
    localparam int VT = VA + VFP + VS + VB;
    localparam int FT = HT * VT;
    localparam logic [9:0] RST_OUT = 10'b11_0000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic [2:0]    fg_index;
    logic          scroll_en;
    logic          hsync, vsync, de, frame_start;
    logic [CB-1:0] r, g, b;

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .TILE_LOG2(T), .COLOR_BITS(CB)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .fg_index(fg_index),
        .scroll_en(scroll_en), .hsync(hsync), .vsync(vsync),
        .r(r), .g(g), .b(b), .de(de), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: raster position feeding the next clock edge
    // and the configuration in force for the current frame.
    int         pos;
    logic [1:0] m_mode;
    logic [2:0] m_fg;
    int         m_scroll;
    int         de_cnt;
    int         hs_lo_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [9:0] expect_out(input int p);
        int h, v, idx;
        bit hs_n, vs_n, act, fs, on;
        logic [CB-1:0] er, eg, eb;
        h    = p % HT;
        v    = p / HT;
        hs_n = !((h >= HA + HFP) && (h < HA + HFP + HS));
        vs_n = !((v >= VA + VFP) && (v < VA + VFP + VS));
        act  = (h < HA) && (v < VA);
        fs   = (h == 0) && (v == 0);
        idx  = int'(m_fg);
        on   = 1'b0;
        if (act) begin
            case (m_mode)
                2'd0: on = 1'b1;
                2'd1: on = ((((h + m_scroll) >> T) ^ (v >> T)) & 1) == 1;
                2'd2: begin on = 1'b1; idx = 7 - h / (HA / 8); end
                default: on = (h == 0) || (h == HA - 1) || (v == 0) || (v == VA - 1);
            endcase
        end
        er = (on && ((idx >> 2) & 1) == 1) ? {CB{1'b1}} : '0;
        eg = (on && ((idx >> 1) & 1) == 1) ? {CB{1'b1}} : '0;
        eb = (on && (idx & 1) == 1)        ? {CB{1'b1}} : '0;
        return {hs_n, vs_n, act, fs, er, eg, eb};
    endfunction

    task automatic randomize_inputs();
        mode      = 2'($urandom_range(0, 3));
        fg_index  = 3'($urandom_range(0, 7));
        scroll_en = 1'($urandom_range(0, 1));
    endtask

    task automatic model_reset();
        pos      = 0;
        m_mode   = 2'd0;
        m_fg     = 3'b111;
        m_scroll = 0;
    endtask

    // One clock: predict, advance model, sample 1 ns after the edge.
    task automatic step(input bit rnd);
        logic [9:0] e;
        int p;
        @(posedge clk);
        p = pos;
        e = expect_out(p);
        if (p == FT - 1) begin
            m_mode = mode;
            m_fg   = fg_index;
            if (scroll_en) m_scroll = (m_scroll + 1) % (1 << (T + 1));
        end
        pos = (p + 1) % FT;
        #1;
        check($sformatf("pix h%0d v%0d", p % HT, p / HT),
              32'({hsync, vsync, de, frame_start, r, g, b}), 32'(e));
        if (de) de_cnt++;
        if (!hsync) hs_lo_cnt++;
        if (rnd && $urandom_range(0, 199) == 0) randomize_inputs();
        if (rnd && pos == FT - 1 && $urandom_range(0, 1) == 1) randomize_inputs();
    endtask

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) step(rnd);
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 2'd0;
        fg_index  = 3'b111;
        scroll_en = 1'b0;
        model_reset();
        #12;
        check("reset_out", 32'({hsync, vsync, de, frame_start, r, g, b}), 32'(RST_OUT));
        #10;
        rst_n = 1'b1;

        // Frame 0 with defaults: timing counts.
        de_cnt = 0; hs_lo_cnt = 0;
        run(FT, 0);
        check("de_count", 32'(de_cnt), 32'(HA * VA));
        check("hsync_low", 32'(hs_lo_cnt), 32'(HS * VT));

        // Solid magenta from frame 2.
        fg_index = 3'b101;
        run(2 * FT, 0);

        // Colour bars.
        mode = 2'd2;
        run(2 * FT, 0);

        // Scrolling checkerboard across a full scroll wrap.
        mode      = 2'd1;
        fg_index  = 3'($urandom_range(1, 7));
        scroll_en = 1'b1;
        run(10 * FT, 0);

        // Solid, then a mid-frame request for border.
        mode      = 2'd0;
        scroll_en = 1'b0;
        run(FT, 0);
        run(12 * HT, 0);
        mode = 2'd3;
        run(FT - 12 * HT, 0);
        run(FT, 0);

        // Random configuration changes, including on the boundary cycle.
        run(8 * FT, 1);

        // Mid-line asynchronous reset.
        run(5 * HT + 17, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'({hsync, vsync, de, frame_start, r, g, b}), 32'(RST_OUT));
        @(posedge clk);
        #2;
        check("rst_hold", 32'({hsync, vsync, de, frame_start, r, g, b}), 32'(RST_OUT));
        rst_n = 1'b1;
        model_reset();
        run(1, 0);
        check("rst_first_fs", 32'(frame_start), 32'(1));
        check("rst_first_rgb", 32'({r, g, b}), 32'({3{{CB{1'b1}}}}));
        run(2 * FT, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised VGA test-pattern generator and the successor to the fixed single-colour bitmap demo top. It contains its own horizontal/vertical timing counters. It produces four selectable patterns: solid, scrolling checkerboard, 8-colour bars and border. Outputs are registered RGB plus sync, aligned and ready for the TinyVGA PMOD mapping in the top-level wrapper. Configuration inputs are sampled once per frame, so mode changes never tear mid-frame.

## Interface
- H_ACTIVE, 640, visible pixels per line; must be divisible by 8
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync and back porch, in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync and back porch, in lines
- TILE_LOG2, 5, log2 of the checkerboard tile edge (tile = 32 px)
- COLOR_BITS, 2, bits per colour channel
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  pattern select: 0 solid, 1 checker, 2 bars, 3 border
- fg_index  in  3  palette index {R,G,B}; each set bit drives that channel to all-ones
- scroll_en  in  1  enables per-frame checkerboard scroll
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- r, g, b  out  COLOR_BITS each  pixel colour; zero outside the active area
- de  out  1  data enable, high for active pixels
- frame_start  out  1  one-cycle pulse at pixel (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL is formed the same way. Counter widths are $clog2 of the totals.
- hcnt counts 0..H_TOTAL-1 and wraps to 0. vcnt increments at each hcnt wrap and wraps at V_TOTAL-1.
- Sync windows:
  - hsync is low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync follows the same rule on vcnt.
  - active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
- Frame boundary is the cycle where hcnt = H_TOTAL-1 and vcnt = V_TOTAL-1. On that cycle:
  - mode and fg_index are latched into cfg_mode and cfg_fg.
  - If scroll_en is high, the scroll offset increments modulo 2^(TILE_LOG2+1).
- Between boundaries the input pins are ignored.
- Palette: fg colour is r = {COLOR_BITS{cfg_fg[2]}}, g = {COLOR_BITS{cfg_fg[1]}}, b = {COLOR_BITS{cfg_fg[0]}}.
- Mode 0 (solid): fg on every active pixel.
- Mode 1 (checker): fg where ((hcnt+scroll) >> TILE_LOG2) ^ (vcnt >> TILE_LOG2) has LSB 1; black otherwise. Scroll is horizontal only.
- Mode 2 (bars): a bar-width counter counts 0..H_ACTIVE/8-1 and increments a 3-bit bar index at each wrap. Both reset at hcnt = 0.
  - Displayed palette index = 7 - bar index: white at left, black at right.
  - No divider is used.
- Mode 3 (border): fg on hcnt ∈ {0, H_ACTIVE-1} or vcnt ∈ {0, V_ACTIVE-1}; black elsewhere.
- Invalid configuration does not occur (2-bit mode decodes fully).

## Timing
- Reset values (asynchronous):
  - hcnt = vcnt = 0
  - hsync = vsync = 1
  - r = g = b = 0, de = 0, frame_start = 0
  - cfg_mode = 0, cfg_fg = 7, scroll = 0, bar counters = 0
- Latency: every output is registered once, 1 cycle after its counter value. hsync, vsync, de, rgb and frame_start stay mutually aligned.
- frame_start is high in the cycle the outputs show pixel (0,0).
- A config change is visible on the first pixel of the next frame. A change made on the boundary cycle itself takes effect at once.
- Reset deassertion mid-frame restarts timing at (0,0) with default config. The first output cycle after release is pixel (0,0), with frame_start = 1.
- Frame period = H_TOTAL*V_TOTAL cycles exactly (800*525 = 420000 at defaults).

## Test plan
- Reset release with defaults: frame_start pulses every 420000 cycles. hsync is low for 96 cycles starting 656 cycles after each line start. vsync is low for lines 490-491. de is high for exactly 640×480 cycles per frame.
- mode=0, fg_index=3'b101: every active pixel has r=3, g=0, b=3. Every blanking pixel is 0/0/0.
- mode=2: pixels 0-79 are white (3,3,3), pixels 80-159 are index 6 (3,3,0), …, pixels 560-639 are black, repeated on every line.
- mode=1, scroll_en=1: pixel (0,0) is black in frame 0. After 32 frames, pixels 0-31 of line 0 show fg. Scroll wraps to 0 after 64 frames.
- mode toggled from 0 to 3 at line 200: the remainder of the current frame stays solid. The next frame shows the border only, and pixel (639,479) = fg.
- rst_n pulsed low mid-line: outputs drop to their reset values asynchronously. After release, the first output is pixel (0,0) with frame_start = 1, in solid white.
